// File: rtl/reg_dump_streamer_pkg.sv
// Shared definitions for the register-dump streamer: FSM encoding and frame constants.
package reg_dump_streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_CAP,
    S_HI,
    S_LO,
    S_CSUM
  } state_t;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam int         FRAME_BYTES = 34;

endpackage

// File: rtl/reg_dump_streamer.sv
// Streams a header, every register as big-endian byte pairs and an XOR checksum
// over a valid/ready byte interface, reading the register file's debug port.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [3:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t                  state, state_nxt;
  logic [3:0]              idx;
  logic [DATA_WIDTH-1:0]   hold;
  logic [7:0]              csum;
  logic                    hs;

  assign hs = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      hold  <= '0;
      csum  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_CSUM) && hs;
      case (state)
        S_IDLE: if (start) begin
          idx  <= '0;
          csum <= '0;
        end
        S_CAP: hold <= rd_data;
        // Data bytes fold into the checksum only when the sink takes them.
        S_HI: if (hs) csum <= csum ^ hold[15:8];
        S_LO: if (hs) begin
          csum <= csum ^ hold[7:0];
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_data   = 8'h00;
    rd_addr   = 4'd0;
    case (state)
      S_IDLE: if (start) state_nxt = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_HDR;
        if (tx_ready) state_nxt = S_RD;
      end
      S_RD: begin
        rd_addr   = idx;
        state_nxt = S_CAP;
      end
      // rd_data answers the previous cycle's address.
      S_CAP: state_nxt = S_HI;
      S_HI: begin
        tx_valid = 1'b1;
        tx_data  = hold[15:8];
        if (tx_ready) state_nxt = S_LO;
      end
      S_LO: begin
        tx_valid = 1'b1;
        tx_data  = hold[7:0];
        if (tx_ready) state_nxt = (idx == LAST_IDX) ? S_CSUM : S_RD;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench: register file model plus a frame-level reference model.
module tb_reg_dump_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] regs [16];
  logic [7:0]  got [$];
  logic [7:0]  exp [$];
  int done_k, done_cnt, stall_bad, last_bad, addr_bad;
  bit timed_out;

  reg_dump_streamer #(.DATA_WIDTH(16), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file debug port: one-cycle read latency.
  always @(posedge clk) rd_data <= regs[rd_addr];

  task automatic build_exp();
    logic [7:0] c;
    c = 8'h00;
    exp.delete();
    exp.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      exp.push_back(regs[i][15:8]);
      exp.push_back(regs[i][7:0]);
      c = c ^ regs[i][15:8] ^ regs[i][7:0];
    end
    exp.push_back(c);
  endtask

  // mode 0: always ready, 1: ready 1010..., 2: random ready.
  // Edge 0 samples start; j counts edges since then.
  task automatic capture(input int mode, input int restart_at);
    logic [7:0] held;
    bit held_v;
    int j;
    got.delete();
    done_k = -1; done_cnt = 0; stall_bad = 0; last_bad = 0; addr_bad = 0;
    timed_out = 0; held_v = 0; held = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    j = 0;
    while (j < 600) begin
      start = 1'b0;
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (j % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = j;
      end
      if (held_v && (!tx_valid || tx_data !== held)) stall_bad++;
      held_v = 0;
      if (tx_valid && rd_addr !== 4'd0) addr_bad++;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (tx_last !== (got.size() == 34)) last_bad++;
        if (restart_at > 0 && got.size() == restart_at) start = 1'b1;
      end else if (tx_valid) begin
        held = tx_data; held_v = 1;
      end
      if (done_k >= 0 && j >= done_k + 6) break;
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    tx_ready = 1'b0;
    if (done_k < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    n_cmp++; if (tx_last !== 1'b0) begin n_bad++; $display("FAIL reset_tx_last got=%b want=0", tx_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (rd_addr !== 4'd0) begin n_bad++; $display("FAIL reset_rd_addr got=%h want=0", rd_addr); end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_priority_busy got=%b want=0", busy); end
  endtask

  task automatic check_frame(input string name, input bit exact_timing);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL %s_timeout got=no_done want=done", name); end
    n_cmp++; if (got.size() != 34) begin n_bad++; $display("FAIL %s_len got=%0d want=34", name, got.size()); end
    for (int i = 0; i < 34 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin n_bad++; $display("FAIL %s_byte%0d got=%h want=%h", name, i, got[i], exp[i]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_pulses got=%0d want=1", name, done_cnt); end
    n_cmp++; if (last_bad != 0) begin n_bad++; $display("FAIL %s_tx_last got=%0d_bad want=0", name, last_bad); end
    n_cmp++; if (addr_bad != 0) begin n_bad++; $display("FAIL %s_rd_addr_idle got=%0d_bad want=0", name, addr_bad); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL %s_stall got=%0d_bad want=0", name, stall_bad); end
    if (exact_timing) begin
      n_cmp++; if (done_k != 66) begin n_bad++; $display("FAIL %s_done_cycle got=%0d want=66", name, done_k); end
    end
  endtask

  task automatic test_zero();
    foreach (regs[i]) regs[i] = 16'h0000;
    build_exp();
    capture(0, 0);
    check_frame("zero", 1);
    n_cmp++; if (got.size() == 34 && got[33] !== 8'h00) begin n_bad++; $display("FAIL zero_csum got=%h want=00", got[33]); end
  endtask

  task automatic test_beef();
    foreach (regs[i]) regs[i] = 16'h0000;
    regs[3] = 16'hBEEF;
    build_exp();
    capture(0, 0);
    check_frame("beef", 1);
    if (got.size() == 34) begin
      n_cmp++; if (got[7] !== 8'hBE) begin n_bad++; $display("FAIL beef_b7 got=%h want=BE", got[7]); end
      n_cmp++; if (got[8] !== 8'hEF) begin n_bad++; $display("FAIL beef_b8 got=%h want=EF", got[8]); end
      n_cmp++; if (got[33] !== 8'h51) begin n_bad++; $display("FAIL beef_csum got=%h want=51", got[33]); end
    end
  endtask

  task automatic test_stall();
    foreach (regs[i]) regs[i] = 16'h0000;
    regs[3] = 16'hBEEF;
    build_exp();
    capture(1, 0);
    check_frame("stall", 0);
  endtask

  task automatic test_abort();
    int n;
    foreach (regs[i]) regs[i] = 16'h0000;
    regs[3] = 16'hBEEF;
    n = 0;
    @(negedge clk); start = 1'b1; tx_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 200 && n < 10; j++) begin
      if (tx_valid && tx_ready) n++;
      if (n < 10) @(negedge clk);
    end
    n_cmp++; if (n != 10) begin n_bad++; $display("FAIL abort_reach10 got=%0d want=10", n); end
    @(negedge clk); reset = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL abort_tx_valid got=%b want=0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    reset = 1'b1;
    @(negedge clk);
    build_exp();
    capture(0, 0);
    check_frame("after_abort", 1);
  endtask

  task automatic test_restart();
    foreach (regs[i]) regs[i] = 16'(($urandom() & 32'hFFFF));
    build_exp();
    capture(0, 5);
    check_frame("restart", 1);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) regs[i] = 16'(16'h0100 * i + i);
    build_exp();
    capture(0, 0);
    check_frame("ramp", 1);
    if (got.size() == 34) begin
      n_cmp++; if (got[31] !== 8'h0F || got[32] !== 8'h0F) begin n_bad++; $display("FAIL ramp_reg15 got=%h%h want=0F0F", got[31], got[32]); end
      n_cmp++; if (got[33] !== 8'h00) begin n_bad++; $display("FAIL ramp_csum got=%h want=00", got[33]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      foreach (regs[i]) regs[i] = 16'(($urandom() & 32'hFFFF));
      build_exp();
      capture(2, 0);
      check_frame("random", 0);
    end
  endtask

  initial begin
    foreach (regs[i]) regs[i] = 16'h0000;
    test_reset();
    test_zero();
    test_beef();
    test_stall();
    test_abort();
    test_restart();
    test_ramp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
